// File: rtl/ram_ctrl.sv
// ----------------------------------------------------------------------------
// ram_ctrl
//
// Sequencing initiator for the ram block. A single-word READ, WRITE or SHIFT
// request is taken from the core over a valid/ready port. The controller then
// runs a fixed chip-select / strobe pattern on the RAM and owns the direction
// of the shared data bus. The result returns as a one-cycle response pulse.
//
// Build option:
//   RAM_CTRL_SHIFT_EN  When defined, SHIFT runs as read / modify / write-back.
//                      When undefined, SHIFT is answered with rsp_err, the
//                      shift datapath is not built, and mem_se, mem_sd and
//                      rsp_ls stay 0.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready is registered)
//   req_op                 00 READ, 01 WRITE, 10 SHIFT, 11 reserved
//   req_addr, req_wdata    target word and WRITE data
//   req_dir                SHIFT direction: 0 left, 1 right
//   rsp_valid              one-cycle response pulse, no backpressure
//   rsp_rdata, rsp_ls      result word and shifted-out bit
//   rsp_err                request rejected without touching the RAM
//   mem_cs/we/re/se/sd     RAM chip select, strobes, shift direction
//   mem_addr, mem_data     RAM address and shared tristate data bus
//
// Phase sequence per request (one clock each):
//   READ/WRITE : SETUP, ACCESS, RESP
//   SHIFT      : SETUP, ACCESS(read), MODIFY, SETUP, ACCESS(write), RESP
//   rejected   : RESP
// ----------------------------------------------------------------------------
module ram_ctrl #(
    parameter int addrs      = 4,
    parameter int block_size = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [addrs-1:0]      req_addr,
    input  logic [block_size-1:0] req_wdata,
    input  logic                  req_dir,
    output logic                  rsp_valid,
    output logic [block_size-1:0] rsp_rdata,
    output logic                  rsp_ls,
    output logic                  rsp_err,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic                  mem_se,
    output logic                  mem_sd,
    output logic [addrs-1:0]      mem_addr,
    inout  wire  [block_size-1:0] mem_data
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        MODIFY,
        RESP
    } state_t;

    state_t                state;
    logic [1:0]            op_q;
    logic                  bus_oe;
    logic [block_size-1:0] bus_dout;

    logic op_ok;     // request can run on the RAM
    logic wr_phase;  // the current SETUP/ACCESS pair is a write
    logic shift_rd;  // the current ACCESS is the read pass of a SHIFT
    logic shift_ls;  // shifted-out bit to report in the response

    // The bus is driven only from a register, so a reset clears the enable
    // and releases the bus asynchronously.
    assign mem_data = bus_oe ? bus_dout : {block_size{1'bz}};

`ifdef RAM_CTRL_SHIFT_EN
    logic dir_q;
    logic wr_pass;   // set while on the write-back pass of a SHIFT
    logic ls_q;

    assign op_ok    = (req_op != 2'b11);
    assign wr_phase = (op_q == OP_WRITE) || wr_pass;
    assign shift_rd = (op_q == OP_SHIFT) && !wr_pass;
    assign shift_ls = wr_pass & ls_q;
`else
    logic unused_dir;

    assign unused_dir = req_dir;
    assign op_ok      = (req_op == OP_READ) || (req_op == OP_WRITE);
    assign wr_phase   = (op_q == OP_WRITE);
    assign shift_rd   = 1'b0;
    assign shift_ls   = 1'b0;
    assign mem_se     = 1'b0;
    assign mem_sd     = 1'b0;
`endif

    // NOTE: every register here, outputs included, is assigned with <= so
    // all of them update together from the values present before the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            op_q      <= OP_READ;
            bus_oe    <= 1'b0;
            bus_dout  <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_ls    <= 1'b0;
            rsp_err   <= 1'b0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
`ifdef RAM_CTRL_SHIFT_EN
            mem_se    <= 1'b0;
            mem_sd    <= 1'b0;
            dir_q     <= 1'b0;
            wr_pass   <= 1'b0;
            ls_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        mem_addr  <= req_addr;
                        bus_dout  <= req_wdata;
`ifdef RAM_CTRL_SHIFT_EN
                        dir_q     <= req_dir;
                        wr_pass   <= 1'b0;
`endif
                        if (op_ok) begin
                            state  <= SETUP;
                            mem_cs <= 1'b1;
                            bus_oe <= (req_op == OP_WRITE);
                        end else begin
                            // Rejected: answer at once, RAM untouched.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_ls    <= 1'b0;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                SETUP: begin
                    state <= ACCESS;
                    if (wr_phase) begin
                        mem_we <= 1'b1;
`ifdef RAM_CTRL_SHIFT_EN
                        mem_se <= wr_pass;
                        mem_sd <= wr_pass & dir_q;
`endif
                    end else begin
                        mem_re <= 1'b1;
                    end
                end

                ACCESS: begin
                    // Strobes and output-enable all drop on the edge that
                    // ends ACCESS; read data is captured on that same edge.
                    mem_we <= 1'b0;
                    mem_re <= 1'b0;
                    bus_oe <= 1'b0;
`ifdef RAM_CTRL_SHIFT_EN
                    mem_se <= 1'b0;
                    mem_sd <= 1'b0;
`endif
                    if (shift_rd) begin
                        // Old word parks in the bus register; MODIFY
                        // rewrites it in place for the write-back pass.
                        bus_dout <= mem_data;
                        state    <= MODIFY;
                    end else begin
                        state     <= RESP;
                        mem_cs    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= (op_q == OP_READ) ? mem_data : bus_dout;
                        rsp_ls    <= shift_ls;
                    end
                end

`ifdef RAM_CTRL_SHIFT_EN
                MODIFY: begin
                    // Turnaround cycle: the bus is still released here and
                    // output-enable comes back on with the next SETUP.
                    if (dir_q) begin
                        bus_dout <= {1'b0, bus_dout[block_size-1:1]};
                        ls_q     <= bus_dout[0];
                    end else begin
                        bus_dout <= {bus_dout[block_size-2:0], 1'b0};
                        ls_q     <= bus_dout[block_size-1];
                    end
                    wr_pass <= 1'b1;
                    bus_oe  <= 1'b1;
                    state   <= SETUP;
                end
`endif

                RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
